// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO multiply-divide unit with sequential shift-add multiply and restoring divide
// One operand-load cycle, 32 iteration cycles and one sign-fix cycle per operation.

module hilo_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  alu_control,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] high,
   output logic [31:0] low,
   output logic        busy
);

   localparam logic [3:0] OP_MULT  = 4'b0000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1101;
   localparam logic [3:0] OP_DIVU  = 4'b1100;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t      state;
   logic [5:0]  count;
   logic        loaded;
   logic        is_div;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic [31:0] orig_a;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] acc;
   logic [32:0] rem;
   logic [31:0] quo;

   logic        code_valid;
   logic        code_signed;
   logic        code_div;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   always_comb begin
      code_valid  = (alu_control == OP_MULT) || (alu_control == OP_MULTU) ||
                    (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
      code_signed = (alu_control == OP_MULT) || (alu_control == OP_DIV);
      code_div    = (alu_control == OP_DIV)  || (alu_control == OP_DIVU);
   end

   // Multiplier bits sit in acc[31:0] and drain out of the bottom as the product fills in.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
      div_shift = {rem[31:0], quo[31]};
      div_diff  = div_shift - {1'b0, mag_b};
   end

   always_comb begin
      prod_fix = neg_q ? (64'd0 - acc) : acc;
      quo_fix  = neg_q ? (32'd0 - quo) : quo;
      rem_fix  = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 6'd0;
         loaded   <= 1'b0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         orig_a   <= 32'd0;
         mag_a    <= 32'd0;
         mag_b    <= 32'd0;
         acc      <= 64'd0;
         rem      <= 33'd0;
         quo      <= 32'd0;
         high     <= 32'd0;
         low      <= 32'd0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && code_valid) begin
                  orig_a   <= op1;
                  mag_a    <= (code_signed && op1[31]) ? (32'd0 - op1) : op1;
                  mag_b    <= (code_signed && op2[31]) ? (32'd0 - op2) : op2;
                  neg_q    <= code_signed && (op1[31] ^ op2[31]);
                  neg_r    <= code_signed && op1[31];
                  div_zero <= (op2 == 32'd0);
                  is_div   <= code_div;
                  count    <= 6'd0;
                  loaded   <= 1'b0;
                  busy     <= 1'b1;
                  state    <= code_div ? DIV : MUL;
               end else begin
                  if (mthi) high <= wdata;
                  if (mtlo) low  <= wdata;
               end
            end
            MUL: begin
               if (!loaded) begin
                  acc    <= {32'd0, mag_b};
                  loaded <= 1'b1;
               end else begin
                  acc   <= {mul_sum, acc[31:1]};
                  count <= count + 6'd1;
                  if (count == 6'd31) state <= FIX;
               end
            end
            DIV: begin
               if (!loaded) begin
                  rem    <= 33'd0;
                  quo    <= mag_a;
                  loaded <= 1'b1;
               end else begin
                  // Restoring step: keep the subtraction only when it does not go negative.
                  if (!div_diff[32]) begin
                     rem <= div_diff;
                     quo <= {quo[30:0], 1'b1};
                  end else begin
                     rem <= div_shift;
                     quo <= {quo[30:0], 1'b0};
                  end
                  count <= count + 6'd1;
                  if (count == 6'd31) state <= FIX;
               end
            end
            FIX: begin
               if (is_div) begin
                  if (div_zero) begin
                     high <= orig_a;
                     low  <= 32'hFFFF_FFFF;
                  end else begin
                     high <= rem_fix;
                     low  <= quo_fix;
                  end
               end else begin
                  high <= prod_fix[63:32];
                  low  <= prod_fix[31:0];
               end
               count  <= 6'd0;
               loaded <= 1'b0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - scoreboard bench for hilo_unit with a reference model of MULT/MULTU/DIV/DIVU

module tb_hilo_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  alu_control;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic [31:0] high;
   logic [31:0] low;
   logic        busy;

   always #5 clk = ~clk;

   hilo_unit dut (
      .clk(clk), .reset(reset), .start(start), .alu_control(alu_control),
      .op1(op1), .op2(op2), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .high(high), .low(low), .busy(busy)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      bit          chk_cycles;
      logic [3:0]  code;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          errors  = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sp;
      logic [63:0] up;
      int          sa;
      int          sbv;
      e.chk_cycles = 1'b1;
      e.code = code;
      e.hi = 32'd0;
      e.lo = 32'd0;
      case (code)
         4'b0000: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp;
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         4'b1001: begin
            up = {32'd0, a} * {32'd0, b};
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         4'b1100: begin
            if (b == 32'd0) begin
               e.hi = a;
               e.lo = 32'hFFFF_FFFF;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
         default: begin
            if (b == 32'd0) begin
               e.hi = a;
               e.lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.hi = 32'd0;
               e.lo = 32'h8000_0000;
            end else begin
               sa = a;
               sbv = b;
               e.lo = sa / sbv;
               e.hi = sa % sbv;
            end
         end
      endcase
      return e;
   endfunction

   // Monitor: checks HI/LO stay frozen while busy and pops the scoreboard when busy falls.
   initial begin
      logic prev_busy;
      int   busy_cnt;
      exp_t e;
      prev_busy = 1'b0;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            busy_cnt++;
            check32("hold_high", high, model_hi);
            check32("hold_low", low, model_lo);
         end else if (prev_busy === 1'b1) begin
            if (sb.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL unexpected_result: got high=%h low=%h expected no completion", high, low);
            end else begin
               e = sb.pop_front();
               check32("result_high", high, e.hi);
               check32("result_low", low, e.lo);
               if (e.chk_cycles) check32("busy_cycles", 32'(busy_cnt), 32'd34);
               model_hi = e.hi;
               model_lo = e.lo;
            end
            busy_cnt = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      if (busy !== 1'b0) begin
         vectors++;
         errors++;
         $display("FAIL idle_timeout: got busy=%b expected 0 within 200 cycles", busy);
      end
   endtask

   task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b, input bit push);
      wait_idle();
      if (push) sb.push_back(model(code, a, b));
      alu_control = code;
      op1 = a;
      op2 = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
      issue(code, a, b, 1'b1);
      wait_idle();
   endtask

   task automatic move_to(input bit to_hi, input bit to_lo, input logic [31:0] d);
      wait_idle();
      mthi = to_hi;
      mtlo = to_lo;
      wdata = d;
      tick();
      mthi = 1'b0;
      mtlo = 1'b0;
      if (to_hi) model_hi = d;
      if (to_lo) model_lo = d;
      check32("mt_high", high, model_hi);
      check32("mt_low", low, model_lo);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] codes [4];
      exp_t       e;
      codes[0] = 4'b0000;
      codes[1] = 4'b1001;
      codes[2] = 4'b1101;
      codes[3] = 4'b1100;

      reset = 1'b1;
      start = 1'b0;
      alu_control = 4'd0;
      op1 = 32'd0;
      op2 = 32'd0;
      mthi = 1'b0;
      mtlo = 1'b0;
      wdata = 32'd0;
      repeat (3) tick();
      reset = 1'b0;
      check32("reset_high", high, 32'd0);
      check32("reset_low", low, 32'd0);
      check32("reset_busy", 32'(busy), 32'd0);

      run_op(4'b0000, 32'hFFFF_FFFD, 32'd5);
      run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(4'b1101, 32'hFFFF_FFF9, 32'd2);
      run_op(4'b1100, 32'd7, 32'd2);
      run_op(4'b1100, 32'd7, 32'd0);
      run_op(4'b1101, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(4'b1101, 32'hFFFF_FFFB, 32'd0);
      run_op(4'b0000, 32'h8000_0000, 32'h8000_0000);

      move_to(1'b1, 1'b0, 32'h1234_5678);
      move_to(1'b0, 1'b1, 32'h0BAD_F00D);
      move_to(1'b1, 1'b1, 32'hCAFE_0001);

      // Unsupported op code must be ignored entirely.
      alu_control = 4'b0011;
      start = 1'b1;
      tick();
      start = 1'b0;
      check32("bad_code_busy", 32'(busy), 32'd0);
      check32("bad_code_high", high, model_hi);
      check32("bad_code_low", low, model_lo);

      // Start wins over a simultaneous MTHI/MTLO.
      wait_idle();
      sb.push_back(model(4'b1100, 32'd1000, 32'd33));
      alu_control = 4'b1100;
      op1 = 32'd1000;
      op2 = 32'd33;
      mthi = 1'b1;
      mtlo = 1'b1;
      wdata = 32'hDEAD_BEEF;
      start = 1'b1;
      tick();
      start = 1'b0;
      mthi = 1'b0;
      mtlo = 1'b0;
      wait_idle();

      // MTLO, MTHI and a new start while busy must not disturb the running multiply.
      issue(4'b1001, 32'h0001_0003, 32'h0002_0007, 1'b1);
      repeat (5) tick();
      mtlo = 1'b1;
      mthi = 1'b1;
      wdata = 32'hAAAA_5555;
      start = 1'b1;
      alu_control = 4'b1100;
      op1 = 32'd9;
      op2 = 32'd0;
      tick();
      mtlo = 1'b0;
      mthi = 1'b0;
      start = 1'b0;
      wait_idle();

      // Reset during a multiply abandons it.
      issue(4'b0000, 32'h7654_3210, 32'h0123_4567, 1'b0);
      repeat (8) tick();
      e.hi = 32'd0;
      e.lo = 32'd0;
      e.chk_cycles = 1'b0;
      e.code = 4'b0000;
      sb.push_back(e);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check32("abort_busy", 32'(busy), 32'd0);
      check32("abort_high", high, 32'd0);
      check32("abort_low", low, 32'd0);

      // Inputs are ignored while reset is held.
      reset = 1'b1;
      start = 1'b1;
      alu_control = 4'b1001;
      mthi = 1'b1;
      wdata = 32'h5555_AAAA;
      tick();
      reset = 1'b0;
      start = 1'b0;
      mthi = 1'b0;
      check32("reset_hold_busy", 32'(busy), 32'd0);
      check32("reset_hold_high", high, 32'd0);

      run_op(4'b1100, 32'd100, 32'd7);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            move_to(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         run_op(codes[$urandom_range(0, 3)], pick_operand(), pick_operand());
      end

      wait_idle();
      tick();
      check32("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
